mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the multicycle RV32 core's memory port: unified instr/data word memory.
//  Accepts one load/store request at a time over a valid/ready handshake.
//  Applies RV32 byte/half/word sizing from func3 and returns data after a fixed latency.
//  Holds the response until the core consumes it; the core's Controller stalls on req_ready/resp_valid.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 32-bit words; valid byte addresses 0 .. 4*DEPTH_WORDS-1
//  LATENCY      2     cycles from request acceptance to resp_valid; legal range 1..15
// PORTS
//  clk         in   1   rising-edge clock
//  rst_n       in   1   reset, asynchronous assert, active-low
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept a request
//  req_we      in   1   1=store, 0=load
//  req_addr    in   32  byte address
//  req_func3   in   3   RV32 load/store func3 (size/sign)
//  req_wdata   in   32  store data, right-aligned
//  resp_valid  out  1   response present
//  resp_ready  in   1   core consumes response
//  resp_rdata  out  32  load result (extended); 0 for stores and errors
//  resp_err    out  1   request rejected: bad func3, out of range, or misaligned (when enabled)
// BEHAVIOUR
//  - Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
//  - Memory array contents are not reset.
//  - FSM: IDLE -(req_valid&&req_ready)-> BUSY -(cnt==LATENCY-1)-> RESP -(resp_ready)-> IDLE.
//  - LATENCY==1: go directly IDLE->RESP.
//  - req_ready=1 only in IDLE. Acceptance edge T: latch result; commit store to array on the same edge.
//  - resp_valid rises at edge T+LATENCY. rdata/err are stable while resp_valid=1.
//  - Once resp_valid=1 it stays 1 until the edge where resp_ready=1.
//  - Back-to-back: the earliest next acceptance is the cycle after the RESP->IDLE edge.
//  - A request may be held through BUSY/RESP; it is ignored until req_ready=1.
//  - Loads:
//    - 000 LB: sign-extend byte addr[1:0].
//    - 001 LH: sign-extend half addr[1].
//    - 010 LW: full word.
//    - 100 LBU / 101 LHU: zero-extend.
//  - Stores:
//    - 000 SB: write wdata[7:0] to lane addr[1:0].
//    - 001 SH: write wdata[15:0] to half addr[1].
//    - 010 SW: write the full word.
//    - Other lanes in the word are untouched.
//  - Any other func3 for the given req_we sets resp_err=1, rdata=0, no write.
//  - Out of range (addr[31:2] >= DEPTH_WORDS) sets resp_err=1, rdata=0, no write, always.
//  - Read after write: a load accepted after a store response returns the stored data.
//  - Reset mid-operation: the pending response is dropped and resp_valid is forced to 0.
//    A store already accepted stays committed.
//  - resp_ready while resp_valid=0 is ignored. req_valid asserted during reset is ignored.
// CONFIGURATION
//  MEMRESP_MISALIGN_ERR_EN defined:
//    - Misaligned access (half with addr[0]=1, word with addr[1:0]!=0) sets resp_err=1, rdata=0, no write.
//  MEMRESP_MISALIGN_ERR_EN undefined:
//    - Offending low address bits are forced to 0 (half: addr[0]; word: addr[1:0]).
//    - The access proceeds aligned with resp_err=0.
// TESTING
//  T1: SW addr 0x10 data 0xDEADBEEF, LATENCY=2.
//      -> resp_valid exactly 2 cycles after acceptance, err=0.
//      -> following LW 0x10 returns 0xDEADBEEF.
//  T2: SB 0x13 data 0x80, then LB 0x13 / LBU 0x13 / LW 0x10.
//      -> 0xFFFFFF80 / 0x00000080 / 0x80ADBEEF.
//  T3: hold resp_ready=0 for 5 cycles after resp_valid.
//      -> resp_valid, resp_rdata constant, req_ready=0 throughout.
//      -> next request accepted only after the consume edge.
//  T4: LW addr 0x1000 with DEPTH_WORDS=1024.
//      -> resp_err=1, rdata=0.
//      -> func3=011 load also gives err=1.
//  T5: LH 0x11.
//      -> with MEMRESP_MISALIGN_ERR_EN: err=1, no write.
//      -> without: returns the sign-extended half at 0x10, err=0.
//  T6: assert rst_n=0 in BUSY after an accepted SW 0x20 0x12345678.
//      -> resp_valid=0, req_ready=1 after release.
//      -> LW 0x20 returns 0x12345678.

Source files
------------

// File: rtl/mem_responder_if.sv
// Memory port bundle between the multicycle RV32 core (master) and the
// memory responder (slave): request handshake, store data and response channel.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_func3;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_func3, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_func3, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Unified instr/data word memory for the multicycle RV32 core: one request at a time,
// RV32 byte/half/word sizing, fixed-latency held response. Option: MEMRESP_MISALIGN_ERR_EN.
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_responder_if.slave  bus
);

  localparam int          AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_responder: LATENCY must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [3:0]     r_cnt, w_cnt_nxt;
  logic [31:0]    r_rdata;
  logic           r_err;
  logic [31:0]    r_mem [DEPTH_WORDS];

  logic           w_accept;
  logic           w_in_range;
  logic           w_f3_ok;
  logic           w_is_half;
  logic           w_is_word;
  logic           w_err;
  logic [1:0]     w_off;
  logic [AW-1:0]  w_idx;
  logic [31:0]    w_word;
  logic [7:0]     w_byte;
  logic [15:0]    w_half;
  logic [31:0]    w_load;
  logic [3:0]     w_be;
  logic [31:0]    w_wlane;
  logic           w_we;

  // ---------------------------------------------------------------- decode
  assign w_accept   = bus.req_valid && (r_state == IDLE) && rst_n;
  assign w_in_range = bus.req_addr[31:2] < 30'(DEPTH_WORDS);
  assign w_idx      = bus.req_addr[AW+1:2];
  assign w_word     = r_mem[w_idx];
  assign w_is_half  = (bus.req_func3[1:0] == 2'b01);
  assign w_is_word  = (bus.req_func3[1:0] == 2'b10);

  always_comb begin
    if (bus.req_we) w_f3_ok = (bus.req_func3 inside {3'b000, 3'b001, 3'b010});
    else            w_f3_ok = (bus.req_func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  end

`ifdef MEMRESP_MISALIGN_ERR_EN
  logic w_misalign;
  assign w_misalign = (w_is_half && bus.req_addr[0]) ||
                      (w_is_word && (bus.req_addr[1:0] != 2'b00));
  assign w_err      = !w_f3_ok || !w_in_range || w_misalign;
  assign w_off      = bus.req_addr[1:0];
`else
  // Misaligned halves/words silently drop the offending low address bits.
  assign w_err      = !w_f3_ok || !w_in_range;
  assign w_off      = w_is_word ? 2'b00 :
                      w_is_half ? {bus.req_addr[1], 1'b0} : bus.req_addr[1:0];
`endif

  // ---------------------------------------------------------------- load path
  assign w_byte = w_word[{w_off, 3'b000} +: 8];
  assign w_half = w_word[{w_off[1], 4'b0000} +: 16];

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned; a missing default infers a latch.
  always_comb begin
    w_load = '0;
    if (!bus.req_we && !w_err) begin
      case (bus.req_func3)
        3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
        3'b001:  w_load = {{16{w_half[15]}}, w_half};
        3'b010:  w_load = w_word;
        3'b100:  w_load = {24'h0, w_byte};
        3'b101:  w_load = {16'h0, w_half};
        default: w_load = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------- store path
  always_comb begin
    w_be    = 4'b0000;
    w_wlane = bus.req_wdata;
    case (bus.req_func3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wlane = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{bus.req_wdata[15:0]}};
      end
      2'b10: begin
        w_be    = 4'b1111;
        w_wlane = bus.req_wdata;
      end
      default: begin
        w_be    = 4'b0000;
        w_wlane = bus.req_wdata;
      end
    endcase
  end

  assign w_we = w_accept && bus.req_we && !w_err;

  // NOTE: the array has no reset branch; clearing storage would force it out of
  // RAM into flops, and software never relies on its power-up contents.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- FSM
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_rdata <= w_load;
        r_err   <= w_err;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (w_accept) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = (LATENCY <= 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == LAT_M1) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt   = r_cnt + 4'd1;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) w_state_nxt = IDLE;
      end
      default: begin
        w_cnt_nxt   = 4'd0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Response fields read as zero whenever no response is being presented.
  assign bus.resp_rdata = (r_state == RESP) ? r_rdata : '0;
  assign bus.resp_err   = (r_state == RESP) ? r_err   : 1'b0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench for mem_responder: sizing, latency, held response,
// range/func3 errors, misalignment handling (MEMRESP_MISALIGN_ERR_EN aware), reset abort.
module tb_mem_responder;

  localparam int DEPTH_WORDS = 1024;
  localparam int LATENCY     = 2;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  mem_responder_if bus ();

  mem_responder #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .LATENCY     (LATENCY)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One complete transaction: drive, accept, time the response, compare, optionally
  // hold the response for `hold` cycles with a competing request, then consume.
  task automatic issue(input string tag, input logic we, input logic [31:0] addr,
                       input logic [2:0] f3, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int hold = 0, input bit early = 1'b0);
    exp_t e;
    int   n;
    @(negedge clk);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_func3 = f3;
    bus.req_wdata = wd;
    sb.push_back('{rd: exp_rd, err: exp_err});
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (early) bus.resp_ready = 1'b1;
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(LATENCY));
    @(negedge clk);
    e = sb.pop_front();
    check({tag, "_rdata"}, bus.resp_rdata, e.rd);
    check({tag, "_err"},   32'(bus.resp_err), 32'(e.err));
    if (hold > 0) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = addr;
      bus.req_func3 = 3'b010;
      bus.req_wdata = 32'h0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, "_hold_valid"}, 32'(bus.resp_valid), 32'd1);
        check({tag, "_hold_rdata"}, bus.resp_rdata, e.rd);
        check({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
      end
      bus.req_valid = 1'b0;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    check({tag, "_consumed"}, 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_func3  = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready",  32'(bus.req_ready),  32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata,      32'd0);
    check("rst_resp_err",   32'(bus.resp_err),   32'd0);
    rst_n = 1'b1;

    // T1: word store then load back
    issue("t1_sw",  1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0,        1'b0);
    issue("t1_lw",  1'b0, 32'h10, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0);

    // T2: byte store, signed/unsigned byte loads, half loads
    issue("t2_sb",  1'b1, 32'h13, 3'b000, 32'h00000080, 32'h0,        1'b0);
    issue("t2_lb",  1'b0, 32'h13, 3'b000, 32'h0,        32'hFFFFFF80, 1'b0);
    issue("t2_lbu", 1'b0, 32'h13, 3'b100, 32'h0,        32'h00000080, 1'b0);
    issue("t2_lw",  1'b0, 32'h10, 3'b010, 32'h0,        32'h80ADBEEF, 1'b0);
    issue("t2_lh",  1'b0, 32'h12, 3'b001, 32'h0,        32'hFFFF80AD, 1'b0);
    issue("t2_lhu", 1'b0, 32'h12, 3'b101, 32'h0,        32'h000080AD, 1'b0);

    // T3: response held 5 cycles with a competing store pending; it must not land
    issue("t3_hold", 1'b0, 32'h10, 3'b010, 32'h0, 32'h80ADBEEF, 1'b0, 5);
    issue("t3_lw",   1'b0, 32'h10, 3'b010, 32'h0, 32'h80ADBEEF, 1'b0);

    // T4: out of range and illegal func3
    issue("t4_lw_oor",  1'b0, 32'h1000, 3'b010, 32'h0,        32'h0, 1'b1);
    issue("t4_ld_f3",   1'b0, 32'h10,   3'b011, 32'h0,        32'h0, 1'b1);
    issue("t4_sw_oor",  1'b1, 32'h1000, 3'b010, 32'h11111111, 32'h0, 1'b1);
    issue("t4_st_f3",   1'b1, 32'h10,   3'b100, 32'h22222222, 32'h0, 1'b1);
    issue("t4_lw_same", 1'b0, 32'h10,   3'b010, 32'h0,        32'h80ADBEEF, 1'b0);
    issue("t4_sw_last", 1'b1, 32'hFFC,  3'b010, 32'hCAFEF00D, 32'h0, 1'b0);
    issue("t4_lw_last", 1'b0, 32'hFFC,  3'b010, 32'h0,        32'hCAFEF00D, 1'b0, 0, 1'b1);

    // T5: misaligned half/word
`ifdef MEMRESP_MISALIGN_ERR_EN
    issue("t5_lh_mis", 1'b0, 32'h11, 3'b001, 32'h0,    32'h0,        1'b1);
    issue("t5_sh_mis", 1'b1, 32'h11, 3'b001, 32'h1234, 32'h0,        1'b1);
    issue("t5_lw_mis", 1'b0, 32'h12, 3'b010, 32'h0,    32'h0,        1'b1);
    issue("t5_lw_chk", 1'b0, 32'h10, 3'b010, 32'h0,    32'h80ADBEEF, 1'b0);
`else
    issue("t5_lh_mis", 1'b0, 32'h11, 3'b001, 32'h0,    32'hFFFFBEEF, 1'b0);
    issue("t5_sh_mis", 1'b1, 32'h11, 3'b001, 32'h1234, 32'h0,        1'b0);
    issue("t5_lw_mis", 1'b0, 32'h12, 3'b010, 32'h0,    32'h80AD1234, 1'b0);
    issue("t5_lw_chk", 1'b0, 32'h10, 3'b010, 32'h0,    32'h80AD1234, 1'b0);
`endif

    // T6: reset while BUSY after an accepted store; request during reset ignored
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h20;
    bus.req_func3 = 3'b010;
    bus.req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("t6_busy_ready", 32'(bus.req_ready), 32'd0);
    rst_n         = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_wdata = 32'hBAD0BAD0;
    #1;
    check("t6_rst_valid", 32'(bus.resp_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t6_rst_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b0;
    rst_n         = 1'b1;
    @(negedge clk);
    check("t6_post_valid", 32'(bus.resp_valid), 32'd0);
    issue("t6_lw", 1'b0, 32'h20, 3'b010, 32'h0, 32'h12345678, 1'b0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
